// File: rtl/calc_display.sv
// calc_display: captures BCD digits offered by a calculator, commits complete
// frames, and multiplexes them onto an 8-digit active-low seven-segment display.
//
// state       | meaning
// MODE_NORMAL | committed digits shown with leading-zero blanking
// MODE_ERROR  | fixed "Erro" image on digits 3..0, held until reset
module calc_display #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       frame_done,
  output logic       err
);

  typedef enum logic {
    MODE_NORMAL = 1'b0,
    MODE_ERROR  = 1'b1
  } mode_e;

  localparam logic [1:0]  ST_ERROR   = 2'b00;
  localparam logic [1:0]  ST_BUSY    = 2'b01;
  localparam logic [1:0]  ST_READY   = 2'b10;
  localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_O     = 7'b0100011;

  logic [7:0][3:0] shadow_q, shadow_d;
  logic [7:0][3:0] disp_q, disp_d;
  logic [7:0]      mask_q, mask_d;
  logic            frame_done_q, frame_done_d;
  mode_e           mode_q, mode_d;
  logic [15:0]     presc_q, presc_d;
  logic [2:0]      scan_q, scan_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic [2:0]      msd;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Writes and commits need different status codes, so they never collide.
  always_comb begin
    shadow_d     = shadow_q;
    mask_d       = mask_q;
    disp_d       = disp_q;
    frame_done_d = 1'b0;
    if (status == ST_BUSY && !pos[3]) begin
      shadow_d[pos[2:0]] = data;
      mask_d[pos[2:0]]   = 1'b1;
    end else if (status == ST_READY && mask_q == 8'hFF) begin
      disp_d       = shadow_q;
      mask_d       = '0;
      frame_done_d = 1'b1;
    end
  end

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_NORMAL: if (status == ST_ERROR) mode_d = MODE_ERROR;
      MODE_ERROR:  mode_d = MODE_ERROR;
    endcase
  end

  always_comb begin
    presc_d = presc_q + 16'd1;
    scan_d  = scan_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      scan_d  = scan_q + 3'd1;
    end
  end

  // Index of the most significant nonzero entry; codes 10..15 count as nonzero.
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (disp_q[i] != 4'd0) msd = 3'(i);
    end
  end

  always_comb begin
    an_d  = ~(8'd1 << scan_q);
    seg_d = SEG_BLANK;
    if (mode_q == MODE_ERROR) begin
      case (scan_q)
        3'd3:       seg_d = SEG_E;
        3'd2, 3'd1: seg_d = SEG_R;
        3'd0:       seg_d = SEG_O;
        default:    seg_d = SEG_BLANK;
      endcase
    end else if (scan_q <= msd) begin
      seg_d = bcd_to_seg(disp_q[scan_q]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q     <= '0;
      disp_q       <= '0;
      mask_q       <= '0;
      frame_done_q <= 1'b0;
      mode_q       <= MODE_NORMAL;
      presc_q      <= '0;
      scan_q       <= '0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
    end else begin
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      mask_q       <= mask_d;
      frame_done_q <= frame_done_d;
      mode_q       <= mode_d;
      presc_q      <= presc_d;
      scan_q       <= scan_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;
  assign err        = (mode_q == MODE_ERROR);

endmodule

// File: tb/tb_calc_display.sv
// Bench for calc_display: a frame-level model checked every cycle, plus
// directed scenarios with literal digit images and frame_done counts.
module tb_calc_display;
  localparam int unsigned SD = 4;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G8 = 7'b0000000, GB = 7'b1111111, GE = 7'b0000110,
                         GR = 7'b0101111, GO = 7'b0100011;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] status = 2'b11;
  logic [3:0] data = 4'd0;
  logic [3:0] pos = 4'd0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       frame_done;
  logic       err;

  calc_display #(.SCAN_DIV(SD)) dut (
    .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
    .an(an), .seg(seg), .frame_done(frame_done), .err(err)
  );

  always #5 clock = ~clock;

  int vec_cnt = 0;
  int miss_cnt = 0;
  int fd_seen = 0;
  bit chk_en = 1'b0;

  logic [3:0]  m_shadow [8] = '{default: 4'd0};
  logic [3:0]  m_disp   [8] = '{default: 4'd0};
  logic [7:0]  m_mask = 8'h00;
  bit          m_err = 1'b0;
  int unsigned ncyc = 0;
  logic [7:0]  exp_an = 8'hFF;
  logic [6:0]  exp_seg = 7'h7F;
  bit          exp_fd = 1'b0;
  bit          exp_err = 1'b0;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int d);
    int top;
    if (m_err) begin
      case (d)
        3:       return GE;
        2, 1:    return GR;
        0:       return GO;
        default: return GB;
      endcase
    end
    top = 0;
    for (int i = 0; i < 8; i++) if (m_disp[i] != 4'd0) top = i;
    if (d > top) return GB;
    return glyph(int'(m_disp[d]));
  endfunction

  // Outputs after an edge reflect the model state just before that edge.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_shadow[i] = 4'd0;
        m_disp[i]   = 4'd0;
      end
      m_mask = 8'h00; m_err = 1'b0; ncyc = 0;
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_fd = 1'b0; exp_err = 1'b0;
    end else begin
      int sc;
      sc = int'((ncyc / SD) % 8);
      exp_an  = ~(8'd1 << sc);
      exp_seg = model_seg(sc);
      exp_fd  = 1'b0;
      if (status == 2'b01 && pos <= 4'd7) begin
        m_shadow[pos[2:0]] = data;
        m_mask[pos[2:0]]   = 1'b1;
      end else if (status == 2'b10 && m_mask == 8'hFF) begin
        m_disp = m_shadow;
        m_mask = 8'h00;
        exp_fd = 1'b1;
      end
      if (status == 2'b00) m_err = 1'b1;
      exp_err = m_err;
      ncyc++;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      if (frame_done === 1'b1) fd_seen++;
      vec_cnt++;
      if (an !== exp_an || seg !== exp_seg || frame_done !== exp_fd || err !== exp_err) begin
        miss_cnt++;
        $display("FAIL cycle t=%0t: an=%h seg=%b fd=%b err=%b, required an=%h seg=%b fd=%b err=%b",
                 $time, an, seg, frame_done, err, exp_an, exp_seg, exp_fd, exp_err);
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
    vec_cnt++;
    if (act !== req) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [1:0] st, input logic [3:0] d, input logic [3:0] p);
    @(negedge clock);
    status = st; data = d; pos = p;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(2'b11, 4'd0, 4'd0);
  endtask

  task automatic commit();
    drive(2'b10, 4'd0, 4'd0);
    idle(2);
  endtask

  task automatic check_digit(input int idx, input logic [6:0] lit, input string name);
    logic [7:0] want_an;
    int k;
    want_an = ~(8'd1 << idx);
    k = 0;
    @(negedge clock);
    while (an !== want_an && k < 8 * SD + 4) begin
      @(negedge clock);
      k++;
    end
    check_lit({name, " an"}, {24'd0, an}, {24'd0, want_an});
    check_lit(name, {25'd0, seg}, {25'd0, lit});
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1; status = 2'b11;
    chk_en = 1'b1;
    @(negedge clock);
    check_lit("reset an", {24'd0, an}, 32'hFF);
    check_lit("reset seg", {25'd0, seg}, 32'h7F);
    #2 reset = 1'b0;
    @(negedge clock);
    check_lit("first edge an", {24'd0, an}, 32'hFE);
    check_lit("first edge seg", {25'd0, seg}, {25'd0, G0});
  endtask

  initial begin
    int k, hold;
    do_reset();

    // idle scan: each digit enable held SD cycles
    k = 0;
    while (an !== 8'hFD && k < 40) begin @(negedge clock); k++; end
    hold = 0;
    while (an === 8'hFD && hold < 40) begin @(negedge clock); hold++; end
    check_lit("an FD hold", hold, SD);
    idle(24);

    // frame 00000123
    fd_seen = 0;
    for (int i = 0; i < 8; i++) drive(2'b01, (i < 3) ? 4'(3 - i) : 4'd0, 4'(i));
    commit();
    check_lit("fd 123", fd_seen, 1);
    check_digit(0, G3, "123 d0");
    check_digit(1, G2, "123 d1");
    check_digit(2, G1, "123 d2");
    check_digit(3, GB, "123 d3");
    check_digit(7, GB, "123 d7");

    // incomplete frame leaves display alone; completing it commits
    fd_seen = 0;
    for (int i = 0; i < 7; i++) drive(2'b01, 4'd0, 4'(i));
    commit();
    check_lit("fd partial", fd_seen, 0);
    check_digit(0, G3, "partial d0");
    check_digit(2, G1, "partial d2");
    drive(2'b01, 4'd5, 4'd7);
    commit();
    check_lit("fd 5000", fd_seen, 1);
    check_digit(7, G5, "5000 d7");
    check_digit(4, G0, "5000 d4");
    check_digit(1, G0, "5000 d1");

    // out-of-range position is ignored
    fd_seen = 0;
    for (int i = 0; i < 7; i++) drive(2'b01, 4'(i), 4'(i));
    drive(2'b01, 4'd7, 4'd9);
    commit();
    check_lit("fd pos9", fd_seen, 0);
    drive(2'b01, 4'd8, 4'd7);
    commit();
    check_lit("fd 8", fd_seen, 1);
    check_digit(7, G8, "pos9 d7");
    check_digit(1, G1, "pos9 d1");

    // frame 42, then error mode
    for (int i = 0; i < 8; i++) drive(2'b01, (i == 0) ? 4'd2 : (i == 1) ? 4'd4 : 4'd0, 4'(i));
    commit();
    check_digit(1, G4, "42 d1");
    check_digit(2, GB, "42 d2");
    drive(2'b00, 4'd0, 4'd0);
    drive(2'b10, 4'd0, 4'd0);
    idle(1);
    check_lit("err set", {31'd0, err}, 1);
    check_digit(3, GE, "err d3");
    check_digit(2, GR, "err d2");
    check_digit(0, GO, "err d0");
    check_digit(5, GB, "err d5");
    fd_seen = 0;
    for (int i = 0; i < 8; i++) drive(2'b01, 4'd9, 4'(i));
    commit();
    check_lit("fd in err", fd_seen, 1);
    check_digit(0, GO, "err commit d0");
    check_digit(3, GE, "err commit d3");
    check_digit(7, GB, "err commit d7");

    // reset mid-frame discards partial writes
    for (int i = 0; i < 8; i++) drive(2'b01, 4'd6, 4'(i));
    commit();
    for (int i = 0; i < 4; i++) drive(2'b01, 4'd7, 4'(i));
    do_reset();
    fd_seen = 0;
    commit();
    check_lit("fd after reset", fd_seen, 0);
    check_lit("err after reset", {31'd0, err}, 0);
    check_digit(0, G0, "rst d0");
    check_digit(1, GB, "rst d1");

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
